cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge.sv | 126 ++++++++++++
 tb/tb_cpu_mem_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// CPU-to-SRAM bridge: accepts single-word CPU loads/stores and drives a
// synchronous single-port SRAM with byte enables. Loads return through a
// registered response with valid/ready backpressure. The bridge also keeps
// read, write and stall performance counters and a sticky protocol-error flag.
module cpu_mem_bridge #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Address,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Write_data,
    input  logic [3:0]        Write_strb,
    output logic              Mem_Req_Ready,
    output logic [31:0]       Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ready,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       stall_cnt,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        proto_err_q;

    logic        in_idle;
    logic        acc_rd;
    logic        acc_wr;
    logic        req_any;
    logic        unused_addr_bits;

    // A request can only be taken in IDLE, and never while reset is held.
    assign in_idle = (state_q == IDLE) && !rst;

    // A read always wins; a concurrent write is dropped. Zero-strobe writes
    // are accepted but never touch the SRAM.
    assign acc_rd  = in_idle && MemRead;
    assign acc_wr  = in_idle && MemWrite && !MemRead && (Write_strb != 4'b0000);
    assign req_any = MemRead || MemWrite;

    assign Mem_Req_Ready   = in_idle;
    assign Read_data_Valid = (state_q == RESP);
    assign Read_data       = rdata_q;

    // SRAM is driven straight from the CPU request in the accept cycle; the
    // word address aliases, dropping the byte offset and all upper bits.
    assign sram_en    = acc_rd || acc_wr;
    assign sram_wen   = acc_wr ? Write_strb : 4'b0000;
    assign sram_addr  = Address[ADDR_W+1:2];
    assign sram_wdata = Write_data;

    assign unused_addr_bits = ^{Address[31:ADDR_W+2], Address[1:0]};

    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign proto_err = proto_err_q;

    // Request/response FSM: capture SRAM data one cycle after the read enable
    // and hold it until the CPU takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rdata_q     <= 32'h0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemRead) begin
                        state_q <= RD_WAIT;
                        if (MemWrite) begin
                            proto_err_q <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    rdata_q <= sram_rdata;
                    state_q <= RESP;
                end
                RESP: begin
                    if (Read_data_Ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free-running performance counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q    <= 32'h0;
            wr_cnt_q    <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (acc_rd) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (acc_wr) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (req_any && !Mem_Req_Ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge with an SRAM model and a response
// scoreboard: expected load data is queued at issue and compared by a
// monitor whenever a response handshake occurs.
module tb_cpu_mem_bridge;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst;
    logic [31:0]       Address;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Write_data;
    logic [3:0]        Write_strb;
    logic              Mem_Req_Ready;
    logic [31:0]       Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;
    logic [31:0]       stall_cnt;
    logic              proto_err;

    int tests;
    int fails;
    logic [31:0] exp_q[$];

    // SRAM model and preload port
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0]       pre_data;

    cpu_mem_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .Address(Address), .MemRead(MemRead),
        .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt), .stall_cnt(stall_cnt), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: byte-masked writes, one-cycle read latency.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (sram_en) begin
            if (sram_wen != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completed handshake.
    always @(negedge clk) begin
        if (Read_data_Valid === 1'b1 && Read_data_Ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL resp_unexpected: got 0x%08h expected no response", Read_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (Read_data !== e) begin
                    fails++;
                    $display("FAIL resp_data: got 0x%08h expected 0x%08h", Read_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        cyc();
        pre_en = 1'b0;
    endtask

    // Full read with Read_data_Ready held high; checks the T / T+1 / T+3 timing.
    task automatic rd(input logic [31:0] a, input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
        MemRead = 1'b1; Address = a; Read_data_Ready = 1'b1;
        exp_q.push_back(ed);
        #2;
        chk("rd_accept_ready", {31'b0, Mem_Req_Ready}, 32'd1);
        chk("rd_sram_en", {31'b0, sram_en}, 32'd1);
        chk("rd_sram_wen", {28'b0, sram_wen}, 32'd0);
        chk("rd_sram_addr", {18'b0, sram_addr}, {18'b0, ea});
        cyc();
        MemRead = 1'b0;
        #2;
        chk("rd_wait_ready", {31'b0, Mem_Req_Ready}, 32'd0);
        chk("rd_wait_en", {31'b0, sram_en}, 32'd0);
        chk("rd_wait_valid", {31'b0, Read_data_Valid}, 32'd0);
        cyc();
        #2;
        chk("rd_resp_valid", {31'b0, Read_data_Valid}, 32'd1);
        cyc();
        #2;
        chk("rd_next_ready", {31'b0, Mem_Req_Ready}, 32'd1);
        chk("rd_next_valid", {31'b0, Read_data_Valid}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic ee, input logic [ADDR_W-1:0] ea);
        MemWrite = 1'b1; Address = a; Write_data = d; Write_strb = s;
        #2;
        chk("wr_accept_ready", {31'b0, Mem_Req_Ready}, 32'd1);
        chk("wr_sram_en", {31'b0, sram_en}, {31'b0, ee});
        chk("wr_sram_wen", {28'b0, sram_wen}, ee ? {28'b0, s} : 32'd0);
        if (ee) begin
            chk("wr_sram_addr", {18'b0, sram_addr}, {18'b0, ea});
            chk("wr_sram_wdata", sram_wdata, d);
        end
        cyc();
        MemWrite = 1'b0; Write_strb = 4'b0000;
        #2;
        chk("wr_stays_idle", {31'b0, Mem_Req_Ready}, 32'd1);
        chk("wr_idle_en", {31'b0, sram_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; Address = 32'h0; MemRead = 1'b1; MemWrite = 1'b0;
        Write_data = 32'h0; Write_strb = 4'b0000; Read_data_Ready = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = 32'h0; sram_rdata = 32'h0;

        // Reset with a pending request: bridge must refuse it.
        cyc();
        #2;
        chk("rst_req_ready", {31'b0, Mem_Req_Ready}, 32'd0);
        chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
        MemRead = 1'b0;
        preload(14'h010, 32'hDEADBEEF);
        preload(14'h005, 32'h11223344);
        preload(14'h006, 32'h55667788);
        preload(14'h007, 32'hCAFEF00D);
        preload(14'h008, 32'h0BADF00D);
        rst = 1'b0;
        #2;
        chk("reset_ready", {31'b0, Mem_Req_Ready}, 32'd1);
        chk("reset_valid", {31'b0, Read_data_Valid}, 32'd0);
        chk("reset_rdata", Read_data, 32'h0);
        chk("reset_rd_cnt", rd_cnt, 32'd0);
        chk("reset_wr_cnt", wr_cnt, 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_proto_err", {31'b0, proto_err}, 32'd0);
        cyc();

        // Basic read
        rd(32'h0000_0040, 14'h010, 32'hDEADBEEF);
        chk("read_rd_cnt", rd_cnt, 32'd1);

        // Byte-lane write then read back
        wr(32'h0000_0014, 32'h0000AA00, 4'b0010, 1'b1, 14'h005);
        chk("bytewr_wr_cnt", wr_cnt, 32'd1);
        rd(32'h0000_0014, 14'h005, 32'h1122AA44);
        chk("bytewr_rd_cnt", rd_cnt, 32'd2);

        // Zero-strobe write is accepted but inert
        wr(32'h0000_0018, 32'hFFFFFFFF, 4'b0000, 1'b0, 14'h006);
        chk("zstrb_wr_cnt", wr_cnt, 32'd1);

        // Aliased address: byte offset and upper bits ignored
        rd(32'h0001_001B, 14'h006, 32'h55667788);
        chk("alias_rd_cnt", rd_cnt, 32'd3);

        // Backpressure: 5 RESP cycles with CPU holding MemRead
        MemRead = 1'b1; Address = 32'h0000_001C; Read_data_Ready = 1'b0;
        exp_q.push_back(32'hCAFEF00D);
        cyc();
        MemRead = 1'b0;
        cyc();
        #2;
        chk("bp_stall_start", stall_cnt, 32'd0);
        MemRead = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_valid_held", {31'b0, Read_data_Valid}, 32'd1);
            chk("bp_data_held", Read_data, 32'hCAFEF00D);
            cyc();
        end
        MemRead = 1'b0; Read_data_Ready = 1'b1;
        #2;
        chk("bp_stall_cnt", stall_cnt, 32'd5);
        chk("bp_rd_cnt", rd_cnt, 32'd4);
        cyc();
        #2;
        chk("bp_back_idle", {31'b0, Mem_Req_Ready}, 32'd1);

        // Conflict: read serviced, write dropped, sticky error
        MemWrite = 1'b1; Write_data = 32'hFFFFFFFF; Write_strb = 4'b1111;
        rd(32'h0000_0020, 14'h008, 32'h0BADF00D);
        MemWrite = 1'b0; Write_strb = 4'b0000;
        chk("conflict_proto_err", {31'b0, proto_err}, 32'd1);
        rd(32'h0000_0020, 14'h008, 32'h0BADF00D);
        chk("conflict_proto_sticky", {31'b0, proto_err}, 32'd1);
        chk("conflict_wr_cnt", wr_cnt, 32'd1);
        chk("conflict_rd_cnt", rd_cnt, 32'd6);

        // Counter wrap
        force dut.rd_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.rd_cnt_q;
        #1;
        chk("wrap_preset", rd_cnt, 32'hFFFFFFFF);
        cyc();
        rd(32'h0000_0040, 14'h010, 32'hDEADBEEF);
        chk("wrap_rd_cnt", rd_cnt, 32'd0);

        // Reset while a response is pending
        MemRead = 1'b1; Address = 32'h0000_0040; Read_data_Ready = 1'b0;
        cyc();
        MemRead = 1'b0;
        cyc();
        #2;
        chk("midrst_in_resp", {31'b0, Read_data_Valid}, 32'd1);
        cyc();
        rst = 1'b1;
        #2;
        chk("midrst_rst_ready", {31'b0, Mem_Req_Ready}, 32'd0);
        cyc();
        rst = 1'b0;
        #2;
        chk("midrst_valid", {31'b0, Read_data_Valid}, 32'd0);
        chk("midrst_ready", {31'b0, Mem_Req_Ready}, 32'd1);
        chk("midrst_rd_cnt", rd_cnt, 32'd0);
        chk("midrst_wr_cnt", wr_cnt, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        chk("midrst_proto_err", {31'b0, proto_err}, 32'd0);
        cyc();
        cyc();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
